// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants, types and helpers for the AES-128 key schedule
package aes_pkg;

  localparam int AES_NR        = 10;
  localparam int AES_KEY_BITS  = 128;
  localparam int AES_WORD_BITS = 32;

  typedef logic [AES_WORD_BITS-1:0] aes_word_t;
  typedef logic [AES_KEY_BITS-1:0]  aes_block_t;

  typedef enum logic [1:0] {
    KEXP_IDLE,
    KEXP_EXPAND,
    KEXP_FIN
  } kexp_state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/round_key_file.sv
// rtl/round_key_file.sv - (NR+1) x 128 round-key storage, one write port, registered read port
module round_key_file
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] waddr,
  input  aes_block_t wdata,
  input  logic [3:0] raddr,
  output aes_block_t rdata
);

  aes_block_t mem_q [NR+1];
  aes_block_t rdata_q;

  // Out-of-range reads return zero rather than aliasing a stored key.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we && (waddr <= 4'(NR))) begin
        mem_q[waddr] <= wdata;
      end
      rdata_q <= (raddr <= 4'(NR)) ? mem_q[raddr] : '0;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - AES-128 key schedule, one round key per clock via an external s_box
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  aes_block_t key_in,
  output logic       busy,
  output logic       done,
  output logic       keys_valid,
  output logic       rk_valid,
  output logic [3:0] rk_index,
  output aes_block_t rk_data,
  input  logic [3:0] rd_index,
  output aes_block_t rd_data,
  output logic [7:0] sbox_addr1,
  output logic [7:0] sbox_addr2,
  output logic [7:0] sbox_addr3,
  output logic [7:0] sbox_addr4,
  input  aes_word_t  sbox_data
);

  kexp_state_t state_q, state_d;
  aes_block_t  cur_key_q, cur_key_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [3:0]  round_q, round_d;
  logic        keys_valid_q, keys_valid_d;
  logic        rk_valid_q, rk_valid_d;
  logic [3:0]  rk_index_q, rk_index_d;
  aes_block_t  rk_data_q, rk_data_d;

  logic        rf_we;
  logic [3:0]  rf_waddr;
  aes_block_t  rf_wdata;

  aes_word_t   w0, w1, w2, w3, t, n0, n1, n2, n3;
  aes_block_t  next_key;

  assign {w0, w1, w2, w3} = cur_key_q;

  // Address rotation is RotWord: the s_box returns SubWord(RotWord(w3)).
  assign sbox_addr1 = w3[23:16];
  assign sbox_addr2 = w3[15:8];
  assign sbox_addr3 = w3[7:0];
  assign sbox_addr4 = w3[31:24];

  assign t        = sbox_data ^ {rcon_q, 24'h0};
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d      = state_q;
    cur_key_d    = cur_key_q;
    rcon_d       = rcon_q;
    round_d      = round_q;
    keys_valid_d = keys_valid_q;
    rk_valid_d   = 1'b0;
    rk_index_d   = rk_index_q;
    rk_data_d    = rk_data_q;
    rf_we        = 1'b0;
    rf_waddr     = round_q;
    rf_wdata     = next_key;
    unique case (state_q)
      KEXP_IDLE: begin
        if (start) begin
          state_d      = KEXP_EXPAND;
          cur_key_d    = key_in;
          rcon_d       = 8'h01;
          round_d      = 4'd1;
          keys_valid_d = 1'b0;
          rk_valid_d   = 1'b1;
          rk_index_d   = 4'd0;
          rk_data_d    = key_in;
          rf_we        = 1'b1;
          rf_waddr     = 4'd0;
          rf_wdata     = key_in;
        end
      end
      KEXP_EXPAND: begin
        rf_we      = 1'b1;
        cur_key_d  = next_key;
        rcon_d     = xtime(rcon_q);
        round_d    = round_q + 4'd1;
        rk_valid_d = 1'b1;
        rk_index_d = round_q;
        rk_data_d  = next_key;
        if (round_q == 4'(NR)) begin
          state_d      = KEXP_FIN;
          keys_valid_d = 1'b1;
        end
      end
      KEXP_FIN: state_d = KEXP_IDLE;
      default:  state_d = KEXP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= KEXP_IDLE;
      cur_key_q    <= '0;
      rcon_q       <= 8'h01;
      round_q      <= '0;
      keys_valid_q <= 1'b0;
      rk_valid_q   <= 1'b0;
      rk_index_q   <= '0;
      rk_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_key_q    <= cur_key_d;
      rcon_q       <= rcon_d;
      round_q      <= round_d;
      keys_valid_q <= keys_valid_d;
      rk_valid_q   <= rk_valid_d;
      rk_index_q   <= rk_index_d;
      rk_data_q    <= rk_data_d;
    end
  end

  round_key_file #(.NR(NR)) u_rkf (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr (rd_index),
    .rdata (rd_data)
  );

  assign busy       = (state_q == KEXP_EXPAND);
  assign done       = (state_q == KEXP_FIN);
  assign keys_valid = keys_valid_q;
  assign rk_valid   = rk_valid_q;
  assign rk_index   = rk_index_q;
  assign rk_data    = rk_data_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - self-checking bench for aes_key_expander with a behavioural s_box
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy, done, keys_valid, rk_valid;
  logic [3:0]   rk_index, rd_index;
  logic [127:0] rk_data, rd_data;
  logic [7:0]   sbox_addr1, sbox_addr2, sbox_addr3, sbox_addr4;
  logic [31:0]  sbox_data;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_rk [11];
  logic [127:0] cap_rk [11];
  int           n_checks = 0;
  int           n_fail   = 0;

  localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always #5 clk = ~clk;

  aes_key_expander dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_valid   (rk_valid),
    .rk_index   (rk_index),
    .rk_data    (rk_data),
    .rd_index   (rd_index),
    .rd_data    (rd_data),
    .sbox_addr1 (sbox_addr1),
    .sbox_addr2 (sbox_addr2),
    .sbox_addr3 (sbox_addr3),
    .sbox_addr4 (sbox_addr4),
    .sbox_data  (sbox_data)
  );

  assign sbox_data = {sbox_tab[sbox_addr1], sbox_tab[sbox_addr2],
                      sbox_tab[sbox_addr3], sbox_tab[sbox_addr4]};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  // S-box from first principles: multiplicative inverse, then the affine map.
  task automatic build_sbox();
    logic [7:0] inv, r1, r2, r3, r4;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      r1 = rotl1(inv);
      r2 = rotl1(r1);
      r3 = rotl1(r2);
      r4 = rotl1(r3);
      sbox_tab[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] rcon_of(input int r);
    case (r)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Textbook word-oriented schedule over w[0..43].
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
        tmp = tmp ^ {rcon_of(i / 4), 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  // Starts in an idle cycle, ends in cycle 12 relative to the start edge.
  task automatic run_expansion(input logic [127:0] key, input logic spur);
    model_expand(key);
    key_in = key;
    start  = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 11; c++) begin
      start = spur && (c == 3 || c == 11);
      chk($sformatf("rk_valid c%0d", c), 128'(rk_valid), 128'(1));
      chk($sformatf("rk_index c%0d", c), 128'(rk_index), 128'(c - 1));
      chk($sformatf("rk_data c%0d", c), rk_data, exp_rk[c-1]);
      chk($sformatf("busy c%0d", c), 128'(busy), 128'(c <= 10));
      chk($sformatf("done c%0d", c), 128'(done), 128'(c == 11));
      chk($sformatf("keys_valid c%0d", c), 128'(keys_valid), 128'(c == 11));
      cap_rk[c-1] = rk_data;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("idle busy", 128'(busy), 128'(0));
    chk("idle rk_valid", 128'(rk_valid), 128'(0));
    chk("idle done", 128'(done), 128'(0));
    chk("idle keys_valid", 128'(keys_valid), 128'(1));
  endtask

  task automatic readback_all();
    for (int i = 0; i < 12; i++) begin
      rd_index = 4'(i);
      @(posedge clk); #1;
      chk($sformatf("rd_data idx%0d", i), rd_data, (i <= 10) ? exp_rk[i] : 128'h0);
      if (i <= 10) chk($sformatf("rd_vs_stream idx%0d", i), rd_data, cap_rk[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    build_sbox();
    rst      = 1'b1;
    start    = 1'b0;
    key_in   = '0;
    rd_index = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset keys_valid", 128'(keys_valid), 128'(0));
    chk("reset rk_valid", 128'(rk_valid), 128'(0));
    chk("reset rk_index", 128'(rk_index), 128'(0));
    chk("reset rk_data", rk_data, 128'h0);
    chk("reset rd_data", rd_data, 128'h0);
    chk("reset sbox_addr", 128'({sbox_addr1, sbox_addr2, sbox_addr3, sbox_addr4}), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_expansion(FIPS_KEY, 1'b1);
    chk("fips rk1", cap_rk[1], FIPS_RK1);
    chk("fips rk10", cap_rk[10], FIPS_RK10);

    run_expansion(128'h0, 1'b0);
    chk("zero rk1", cap_rk[1], ZERO_RK1);
    chk("zero rk10", cap_rk[10], ZERO_RK10);
    readback_all();

    for (int n = 0; n < 4; n++) begin
      run_expansion({$urandom, $urandom, $urandom, $urandom}, 1'(n & 1));
      readback_all();
    end

    key_in = FIPS_KEY;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort keys_valid", 128'(keys_valid), 128'(0));
    chk("abort done", 128'(done), 128'(0));
    chk("abort rk_valid", 128'(rk_valid), 128'(0));
    rd_index = 4'd0;
    @(posedge clk); #1;
    chk("abort rd idx0", rd_data, 128'h0);
    rd_index = 4'd3;
    @(posedge clk); #1;
    chk("abort rd idx3", rd_data, 128'h0);

    run_expansion(FIPS_KEY, 1'b0);
    chk("refips rk1", cap_rk[1], FIPS_RK1);
    chk("refips rk10", cap_rk[10], FIPS_RK10);
    readback_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
